// File: rtl/cdec_prog_pkg.sv
// Shared encodings for the synchronous memory programmer: operation codes,
// sequencer states and the board-level debounce default.
package cdec_prog_pkg;

   // Operation selected on the op switches when the key is pressed
   typedef enum logic [1:0] {
      OP_READ  = 2'b00,   // step to next address and read it back
      OP_WRITE = 2'b01,   // write switch code, then step and read
      OP_LOAD  = 2'b10,   // jump to the address given on the switches
      OP_NOP   = 2'b11
   } op_e;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WRITE   = 3'd1,
      ST_INCR    = 3'd2,
      ST_FETCH   = 3'd3,
      ST_CAPTURE = 3'd4
   } state_e;

   // About 1 ms of stable key level at a 50 MHz system clock
   localparam int DEB_CYCLES_DEF = 50000;

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioning: two-flop synchroniser, stability counter and a
// single-clock pulse on an accepted press (accepted 1 -> 0 level change).
module key_debounce
   import cdec_prog_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clock,
   input  logic reset_N,
   input  logic key_n,
   output logic press_evt
);

   localparam int CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

   logic             sync1_q;
   logic             sync2_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             level_q;
   logic             level_d;
   logic             evt_q;
   logic             evt_d;

   // Bring the raw key into the clock domain; idle level is released (1)
   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= key_n;
         sync2_q <= sync1_q;
      end
   end

   // Count consecutive samples that differ from the accepted level; the
   // DEB_CYCLES-th such sample in a row flips the level. Any sample equal
   // to the accepted level restarts the count, so short bounces vanish.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      evt_d   = 1'b0;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
         cnt_d   = '0;
         level_d = sync2_q;
         evt_d   = ~sync2_q;   // only the press direction produces an event
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Debounce state and registered press pulse
   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) begin
         cnt_q   <= '0;
         level_q <= 1'b1;
         evt_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
         evt_q   <= evt_d;
      end
   end

   assign press_evt = evt_q;

endmodule

// File: rtl/mem_programmer_sync.sv
// Synchronous memory programmer. A debounced key press starts a short
// sequence on a synchronous-read memory: write-and-step, step-read, or
// load-address, each ending with the read-back of the current address.
module mem_programmer_sync
   import cdec_prog_pkg::*;
#(
   parameter int                ADDR_W     = 8,
   parameter int                DATA_W     = 8,
   parameter logic [ADDR_W-1:0] LAST_ADRS  = {ADDR_W{1'b1}},
   parameter int                DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic              clock,
   input  logic              reset_N,
   input  logic              prog_key,
   input  logic              prog_en,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] prog_code,
   input  logic [DATA_W-1:0] mm_q,
   output logic [ADDR_W-1:0] pr_adrs,
   output logic [DATA_W-1:0] pr_code,
   output logic              pr_wr_en,
   output logic [DATA_W-1:0] data,
   output logic              busy,
   output logic              wrap
);

   state_e            state_q;
   state_e            state_d;
   logic [ADDR_W-1:0] adrs_q;
   logic [ADDR_W-1:0] adrs_d;
   logic [DATA_W-1:0] code_q;
   logic [DATA_W-1:0] code_d;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_d;
   logic              press_evt;
   logic              at_last;

   // Switch code reused as an address: zero-extend when narrower, keep the
   // low ADDR_W bits when wider.
   function automatic logic [ADDR_W-1:0] load_adrs(input logic [DATA_W-1:0] c);
      logic [ADDR_W+DATA_W-1:0] ext;
      ext = {{ADDR_W{1'b0}}, c};
      return ext[ADDR_W-1:0];
   endfunction

   key_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_deb (
      .clock     (clock),
      .reset_N   (reset_N),
      .key_n     (prog_key),
      .press_evt (press_evt)
   );

   assign at_last = (adrs_q == LAST_ADRS);

   // Sequencer next state and datapath updates. Leaving program mode drops
   // back to IDLE from anywhere while keeping address and read-back.
   always_comb begin
      state_d = state_q;
      adrs_d  = adrs_q;
      code_d  = code_q;
      data_d  = data_q;
      if (!prog_en) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (press_evt) begin
                  case (op_e'(op))
                     OP_WRITE: begin
                        state_d = ST_WRITE;
                        code_d  = prog_code;
                     end
                     OP_READ: begin
                        state_d = ST_INCR;
                     end
                     OP_LOAD: begin
                        state_d = ST_FETCH;
                        adrs_d  = load_adrs(prog_code);
                     end
                     default: begin
                        state_d = ST_IDLE;
                     end
                  endcase
               end
            end
            ST_WRITE: begin
               state_d = ST_INCR;
            end
            ST_INCR: begin
               adrs_d  = at_last ? '0 : adrs_q + 1'b1;
               state_d = ST_FETCH;
            end
            ST_FETCH: begin
               // memory samples the stable address on this edge
               state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
               data_d  = mm_q;
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers; reset starts with a fetch of address 0
   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) begin
         state_q <= ST_FETCH;
         adrs_q  <= '0;
         code_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         adrs_q  <= adrs_d;
         code_q  <= code_d;
         data_q  <= data_d;
      end
   end

   // Strobes decoded from state; prog_en gates them without waiting a clock
   assign pr_wr_en = (state_q == ST_WRITE) & prog_en;
   assign wrap     = (state_q == ST_INCR) & prog_en & at_last;
   assign busy     = (state_q != ST_IDLE);
   assign pr_adrs  = adrs_q;
   assign pr_code  = code_q;
   assign data     = data_q;

endmodule
